hack_mem_arbiter: RTL and testbench
===================================

// Module: hack_mem_arbiter
// PURPOSE
//  Shares one synchronous single-port Hack RAM (16-bit words, 15-bit address) between two
//  requesters: port 0 (CPU) and port 1 (screen scanner / DMA). Round-robin arbitration
//  with an optional lock for atomic read-modify-write sequences. Sits between the CPU/video
//  masters and the RAM macro; the RAM returns read data one cycle after mem_en_o.
// PARAMETERS
//  AW            15  address width
//  DW            16  data width
//  LOCK_TIMEOUT  16  idle cycles in a lock state before forced release (>=1)
// PORTS
//  clk_i         in   1   clock, all state on rising edge
//  rst_n_i       in   1   asynchronous active-low reset
//  mN_req_i      in   1   (N=0,1) access request; held until mN_gnt_o seen high at a clock edge
//  mN_we_i       in   1   1=write, 0=read; qualified by mN_req_i
//  mN_lock_i     in   1   keep ownership after this access
//  mN_addr_i     in   AW  word address
//  mN_wdata_i    in   DW  write data
//  mN_gnt_o      out  1   access accepted this cycle (combinational from req/state)
//  mN_rvalid_o   out  1   read data valid (registered, one cycle after granted read)
//  mN_rdata_o    out  DW  read data, = mem_rdata_i when mN_rvalid_o=1, else 0
//  mem_en_o      out  1   RAM access strobe (= m0_gnt_o | m1_gnt_o)
//  mem_we_o      out  1   RAM write enable, winner's we
//  mem_addr_o    out  AW  winner's address (0 when mem_en_o=0)
//  mem_wdata_o   out  DW  winner's write data (0 when mem_en_o=0)
//  mem_rdata_i   in   DW  RAM read data, valid the cycle after a read strobe
//  lock_err_o    out  1   one-cycle pulse on lock timeout
// BEHAVIOUR
//  - Reset: state=IDLE, last_q=1 (port 0 wins first tie), rd_owner/rvalid cleared,
//    timeout counter=0, lock_err_o=0; all gnt/mem outputs 0 while rst_n_i=0.
//  - At most one grant per cycle; a grant is exactly one RAM access.
//  - IDLE: only one req -> grant it. Both -> grant port != last_q. Grant updates last_q.
//    Granted with mN_lock_i=1 -> next state LOCKN.
//  - LOCKN: only port N may be granted; other port stalls regardless of req.
//    Granted with lock_i=0 -> IDLE (last_q=N). Granted with lock_i=1 -> stay, counter=0.
//    Cycle without mN_req_i -> counter+1; counter reaching LOCK_TIMEOUT -> IDLE,
//    lock_err_o pulses 1 cycle, last_q=N, counter=0.
//  - Read latency: granted read in cycle T -> mN_rvalid_o=1, mN_rdata_o=mem_rdata_i in T+1.
//    Writes produce no rvalid. Back-to-back reads, including alternating ports, run at
//    one access per cycle; each rvalid follows its own grant.
//  - Simultaneous read by winner in T and new grant in T+1: independent, no bubble.
//  - Reset asserted mid-operation: in-flight rvalid dropped, lock released, no pulse.
//  - Address/data widths pass straight through; no wrap or arithmetic.
// TESTING
//  1. Port 0 only: read addr 0x0010 (RAM holds 0x1234) -> m0_gnt_o=1 cycle T,
//     m0_rvalid_o=1, m0_rdata_o=0x1234 at T+1; m1 outputs stay 0.
//  2. Both req every cycle after reset -> grants alternate 0,1,0,1; mem_addr_o follows
//     winner; each port gets rvalid one cycle after its grant.
//  3. Port 1 locked RMW: read 0x4000 lock=1, write 0x4000=0xBEEF lock=0 while m0 reqs ->
//     m0 stalled exactly 2 cycles, then granted; RAM[0x4000]=0xBEEF.
//  4. Port 0 takes lock then drops req for 16 cycles -> lock_err_o pulses once on 16th
//     idle cycle; m1 granted the following cycle.
//  5. Port 0 write 0x0005=0x00FF -> mem_we_o=1, mem_wdata_o=0x00FF, no m0_rvalid_o.
//  6. rst_n_i low in the cycle after a granted read -> m0_rvalid_o=0, state IDLE,
//     first tie after release goes to port 0.

Source files
------------

// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter
//   Shares one synchronous single-port Hack RAM between two masters:
//   port 0 (CPU) and port 1 (screen scanner / DMA). Ties are resolved
//   round-robin. A master may hold a lock across accesses so that a
//   read-modify-write cannot be split. A lock that goes unused for
//   LOCK_TIMEOUT cycles is forcibly released.
//
// Ports
//   clk_i, rst_n_i              clock, async active-low reset
//   mN_req_i / mN_we_i          request, write enable (N = 0,1)
//   mN_lock_i                   keep ownership after this access
//   mN_addr_i / mN_wdata_i      word address, write data
//   mN_gnt_o                    access accepted this cycle (combinational)
//   mN_rvalid_o / mN_rdata_o    read return, one cycle after a granted read
//   mem_en_o / mem_we_o         RAM strobe and write enable
//   mem_addr_o / mem_wdata_o    RAM address and write data (0 when idle)
//   mem_rdata_i                 RAM read data, valid the cycle after a read
//   lock_err_o                  one-cycle pulse when a lock times out
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; round-robin between requesters
// LOCK0   | port 0 owns the RAM; port 1 stalls
// LOCK1   | port 1 owns the RAM; port 0 stalls
module hack_mem_arbiter #(
  parameter int AW           = 15,
  parameter int DW           = 16,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          lock_err_o
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;     // port that won the most recent grant
  logic [CW-1:0] cnt_q, cnt_d;       // idle cycles spent in a lock state
  logic          rvalid0_q, rvalid1_q;
  logic          gnt0, gnt1, err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= m0_gnt_o & ~m0_we_i;
      rvalid1_q <= m1_gnt_o & ~m1_we_i;
    end
  end

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    err     = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // on a tie the port that did not win last time goes first
        if (m0_req_i && (!m1_req_i || last_q)) begin
          gnt0   = 1'b1;
          last_d = 1'b0;
          cnt_d  = '0;
          if (m0_lock_i) state_d = LOCK0;
        end else if (m1_req_i) begin
          gnt1   = 1'b1;
          last_d = 1'b1;
          cnt_d  = '0;
          if (m1_lock_i) state_d = LOCK1;
        end
      end
      LOCK0: begin
        if (m0_req_i) begin
          gnt0   = 1'b1;
          last_d = 1'b0;
          cnt_d  = '0;
          if (!m0_lock_i) state_d = IDLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          err     = 1'b1;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCK1: begin
        if (m1_req_i) begin
          gnt1   = 1'b1;
          last_d = 1'b1;
          cnt_d  = '0;
          if (!m1_lock_i) state_d = IDLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          err     = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // grants and the error pulse are combinational, so they are masked
  // directly by reset to keep the RAM quiet while reset is held
  assign m0_gnt_o   = gnt0 & rst_n_i;
  assign m1_gnt_o   = gnt1 & rst_n_i;
  assign lock_err_o = err & rst_n_i;
  assign mem_en_o   = m0_gnt_o | m1_gnt_o;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (m1_gnt_o) begin
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
    end else if (m0_gnt_o) begin
      mem_we_o    = m0_we_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
    end
  end

  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m0_rdata_o  = rvalid0_q ? mem_rdata_i : '0;
  assign m1_rdata_o  = rvalid1_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
module tb_hack_mem_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [14:0] m0_addr;
  logic [15:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [14:0] m1_addr;
  logic [15:0] m1_wdata, m1_rdata;
  logic        mem_en, mem_we, lock_err;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  hack_mem_arbiter #(.AW(15), .DW(16), .LOCK_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .lock_err_o(lock_err)
  );

  // behavioural RAM: read data appears the cycle after the strobe
  logic [15:0] ram [0:32767];
  logic [15:0] ram_rd = 16'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rd <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rd;

  typedef struct {
    bit          g0, g1, en, we, err;
    logic [14:0] addr;
    logic [15:0] wdata;
  } cyc_exp_t;

  typedef struct {
    int          stamp;
    logic [15:0] data;
  } rd_exp_t;

  cyc_exp_t cq[$];
  rd_exp_t  rq0[$], rq1[$];
  int       cur_cyc = 0;
  int       tests = 0;
  int       fails = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cur_cyc, act, exp);
    end
  endfunction

  // one clock cycle of stimulus plus the hand-computed expectation for it
  task automatic cyc(input bit rst,
                     input bit r0, input bit w0, input bit l0,
                     input logic [14:0] a0, input logic [15:0] d0,
                     input bit r1, input bit w1, input bit l1,
                     input logic [14:0] a1, input logic [15:0] d1,
                     input bit g0, input bit g1, input bit err,
                     input logic [15:0] rd, input bit rv);
    cyc_exp_t e;
    @(posedge clk);
    #1;
    cur_cyc++;
    rst_n   = rst;
    m0_req  = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req  = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    e.g0    = g0;
    e.g1    = g1;
    e.err   = err;
    e.en    = g0 | g1;
    e.we    = g1 ? w1 : (g0 ? w0 : 1'b0);
    e.addr  = g1 ? a1 : (g0 ? a0 : 15'h0);
    e.wdata = g1 ? d1 : (g0 ? d0 : 16'h0);
    cq.push_back(e);
    if (g0 && !w0 && rv) rq0.push_back('{cur_cyc, rd});
    if (g1 && !w1 && rv) rq1.push_back('{cur_cyc, rd});
  endtask

  task automatic idle(input bit err = 1'b0);
    cyc(Y, N,N,N,15'h0,16'h0, N,N,N,15'h0,16'h0, N,N,err,16'h0,N);
  endtask

  // monitor: mid-cycle, compare what the DUT presents against the queues
  cyc_exp_t me;
  rd_exp_t  mr;
  bit       exp_rv0, exp_rv1;
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      me = cq.pop_front();
      check("m0_gnt",    32'(m0_gnt),    32'(me.g0));
      check("m1_gnt",    32'(m1_gnt),    32'(me.g1));
      check("mem_en",    32'(mem_en),    32'(me.en));
      check("mem_we",    32'(mem_we),    32'(me.we));
      check("mem_addr",  32'(mem_addr),  32'(me.addr));
      check("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
      check("lock_err",  32'(lock_err),  32'(me.err));

      exp_rv0 = (rq0.size() > 0) && (rq0[0].stamp == cur_cyc - 1);
      check("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
      if (exp_rv0) begin
        mr = rq0.pop_front();
        if (m0_rvalid) check("m0_rdata", 32'(m0_rdata), 32'(mr.data));
      end else if (!m0_rvalid) begin
        check("m0_rdata_zero", 32'(m0_rdata), 32'h0);
      end

      exp_rv1 = (rq1.size() > 0) && (rq1[0].stamp == cur_cyc - 1);
      check("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
      if (exp_rv1) begin
        mr = rq1.pop_front();
        if (m1_rvalid) check("m1_rdata", 32'(m1_rdata), 32'(mr.data));
      end else if (!m1_rvalid) begin
        check("m1_rdata_zero", 32'(m1_rdata), 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'h0;
    ram[15'h0010] = 16'h1234;
    ram[15'h0011] = 16'h1111;
    ram[15'h0012] = 16'h3333;
    ram[15'h0020] = 16'hAAAA;
    ram[15'h0021] = 16'h2222;
    ram[15'h0300] = 16'h7777;
    ram[15'h4000] = 16'h0BAD;

    rst_n = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    #1 rst_n = 1'b0;

    // reset held with both requesting: nothing may reach the RAM
    cyc(N, Y,N,N,15'h0010,16'h0, Y,N,N,15'h0020,16'h0, N,N,N,16'h0,N);
    cyc(N, Y,N,N,15'h0010,16'h0, Y,N,N,15'h0020,16'h0, N,N,N,16'h0,N);

    // single read by port 0
    cyc(Y, Y,N,N,15'h0010,16'h0, N,N,N,15'h0,16'h0, Y,N,N,16'h1234,Y);
    idle();

    // fresh reset, then both request every cycle: 0,1,0,1
    cyc(N, N,N,N,15'h0,16'h0, N,N,N,15'h0,16'h0, N,N,N,16'h0,N);
    cyc(Y, Y,N,N,15'h0010,16'h0, Y,N,N,15'h0020,16'h0, Y,N,N,16'h1234,Y);
    cyc(Y, Y,N,N,15'h0011,16'h0, Y,N,N,15'h0020,16'h0, N,Y,N,16'hAAAA,Y);
    cyc(Y, Y,N,N,15'h0011,16'h0, Y,N,N,15'h0021,16'h0, Y,N,N,16'h1111,Y);
    cyc(Y, Y,N,N,15'h0012,16'h0, Y,N,N,15'h0021,16'h0, N,Y,N,16'h2222,Y);
    cyc(Y, Y,N,N,15'h0012,16'h0, N,N,N,15'h0,16'h0, Y,N,N,16'h3333,Y);
    idle();

    // port 0 write, then read it back
    cyc(Y, Y,Y,N,15'h0005,16'h00FF, N,N,N,15'h0,16'h0, Y,N,N,16'h0,N);
    idle();
    cyc(Y, Y,N,N,15'h0005,16'h0, N,N,N,15'h0,16'h0, Y,N,N,16'h00FF,Y);

    // port 1 locked read-modify-write; port 0 stalls two cycles
    cyc(Y, Y,N,N,15'h0300,16'h0, Y,N,Y,15'h4000,16'h0,    N,Y,N,16'h0BAD,Y);
    cyc(Y, Y,N,N,15'h0300,16'h0, Y,Y,N,15'h4000,16'hBEEF, N,Y,N,16'h0,N);
    cyc(Y, Y,N,N,15'h0300,16'h0, N,N,N,15'h0,16'h0,       Y,N,N,16'h7777,Y);
    cyc(Y, Y,N,N,15'h4000,16'h0, N,N,N,15'h0,16'h0,       Y,N,N,16'hBEEF,Y);
    idle();

    // port 0 lock; a locked re-grant restarts the timeout; then 16 idle cycles
    cyc(Y, Y,N,Y,15'h0010,16'h0, N,N,N,15'h0,16'h0, Y,N,N,16'h1234,Y);
    for (int i = 0; i < 10; i++)
      cyc(Y, N,N,N,15'h0,16'h0, Y,N,N,15'h0021,16'h0, N,N,N,16'h0,N);
    cyc(Y, Y,N,Y,15'h0011,16'h0, Y,N,N,15'h0021,16'h0, Y,N,N,16'h1111,Y);
    for (int i = 1; i <= 16; i++)
      cyc(Y, N,N,N,15'h0,16'h0, Y,N,N,15'h0021,16'h0, N,N,(i == 16),16'h0,N);
    cyc(Y, N,N,N,15'h0,16'h0, Y,N,N,15'h0021,16'h0, N,Y,N,16'h2222,Y);
    idle();

    // reset the cycle after a granted locked read: return dropped, lock gone
    cyc(Y, Y,N,Y,15'h0010,16'h0, N,N,N,15'h0,16'h0, Y,N,N,16'h1234,N);
    cyc(N, Y,N,N,15'h0011,16'h0, Y,N,N,15'h0020,16'h0, N,N,N,16'h0,N);
    cyc(Y, Y,N,N,15'h0011,16'h0, Y,N,N,15'h0020,16'h0, Y,N,N,16'h1111,Y);
    cyc(Y, N,N,N,15'h0,16'h0,    Y,N,N,15'h0020,16'h0, N,Y,N,16'hAAAA,Y);
    idle();
    idle();

    @(negedge clk);
    #1;
    check("cycle_queue_drained", 32'(cq.size()),  32'h0);
    check("m0_reads_returned",   32'(rq0.size()), 32'h0);
    check("m1_reads_returned",   32'(rq1.size()), 32'h0);
    check("ram_4000_written",    32'(ram[15'h4000]), 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
